// File: rtl/nmos_halfbridge_driver_pkg.sv
// Shared types and helpers for the NMOS half-bridge gate driver.
// Channel state encoding and dead-time load value.
package nmos_drv_pkg;

   typedef enum logic [2:0] {
      OFF,
      DEAD,
      LO_ON,
      HI_ON,
      FAULT
   } hb_state_t;

   localparam int unsigned DEAD_MIN = 1;

   // A zero dead time still gives one non-overlap cycle
   function automatic int unsigned dead_cnt(input int unsigned dt);
      return (dt < DEAD_MIN) ? DEAD_MIN : dt;
   endfunction

endpackage

// File: rtl/nmos_halfbridge_driver_if.sv
// Control/status bundle of the half-bridge gate driver.
// master drives commands, slave (the driver) returns gate drives.
interface nmos_halfbridge_driver_if #(
   parameter int CHANNELS = 4,
   parameter int DEAD_W   = 8
);
   logic                enable;
   logic [DEAD_W-1:0]   dead_time;
   logic [CHANNELS-1:0] cmd;
   logic                fault;
   logic [CHANNELS-1:0] gate_hi;
   logic [CHANNELS-1:0] gate_lo;
   logic [CHANNELS-1:0] busy;
   logic                fault_latched;

   modport master (
      output enable, dead_time, cmd, fault,
      input  gate_hi, gate_lo, busy, fault_latched
   );

   modport slave (
      input  enable, dead_time, cmd, fault,
      output gate_hi, gate_lo, busy, fault_latched
   );
endinterface

// File: rtl/nmos_halfbridge_driver_hb_channel.sv
// One half-bridge channel: state machine, dead counter, gate flops.
// Gates only rise after a full dead interval with both gates low.
module hb_channel
   import nmos_drv_pkg::*;
#(
   parameter int DEAD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              kill,
   input  logic              cmd,
   input  logic [DEAD_W-1:0] dead_time,
   output logic              gate_hi,
   output logic              gate_lo,
   output logic              busy
);

   hb_state_t         state;
   logic [DEAD_W-1:0] cnt;
   logic [DEAD_W-1:0] load;

   assign load = DEAD_W'(dead_cnt(32'(dead_time)));

   // Channel FSM with registered gate and busy outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= OFF;
         cnt     <= '0;
         gate_hi <= 1'b0;
         gate_lo <= 1'b0;
         busy    <= 1'b0;
      end else if (kill) begin
         state   <= FAULT;
         cnt     <= '0;
         gate_hi <= 1'b0;
         gate_lo <= 1'b0;
         busy    <= 1'b0;
      end else if (!enable) begin
         state   <= OFF;
         cnt     <= '0;
         gate_hi <= 1'b0;
         gate_lo <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            DEAD: begin
               if (cnt > DEAD_W'(1)) begin
                  cnt <= cnt - DEAD_W'(1);
               end else begin
                  cnt     <= '0;
                  busy    <= 1'b0;
                  state   <= cmd ? HI_ON : LO_ON;
                  gate_hi <= cmd;
                  gate_lo <= !cmd;
               end
            end
            LO_ON: begin
               if (cmd) begin
                  state   <= DEAD;
                  cnt     <= load;
                  gate_lo <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            HI_ON: begin
               if (!cmd) begin
                  state   <= DEAD;
                  cnt     <= load;
                  gate_hi <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            default: begin
               state   <= DEAD;
               cnt     <= load;
               gate_hi <= 1'b0;
               gate_lo <= 1'b0;
               busy    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/nmos_halfbridge_driver.sv
// Multi-channel NMOS half-bridge gate driver with dead time.
// Holds the sticky fault flag and fans shared controls out to channels.
module nmos_halfbridge_driver
   import nmos_drv_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DEAD_W   = 8
) (
   input  logic clk,
   input  logic rst_n,
   nmos_halfbridge_driver_if.slave bus
);

   logic                fl;
   logic                kill;
   logic [CHANNELS-1:0] hi;
   logic [CHANNELS-1:0] lo;
   logic [CHANNELS-1:0] bsy;

   // A latched fault keeps channels down until enable is dropped
   assign kill = bus.fault | (fl & bus.enable);

   // Sticky fault: set by fault, cleared on an edge with enable low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fl <= 1'b0;
      else        fl <= kill;
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      hb_channel #(
         .DEAD_W (DEAD_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .enable    (bus.enable),
         .kill      (kill),
         .cmd       (bus.cmd[i]),
         .dead_time (bus.dead_time),
         .gate_hi   (hi[i]),
         .gate_lo   (lo[i]),
         .busy      (bsy[i])
      );
   end

   assign bus.gate_hi       = hi;
   assign bus.gate_lo       = lo;
   assign bus.busy          = bsy;
   assign bus.fault_latched = fl;

endmodule

// File: tb/tb_nmos_halfbridge_driver.sv
// Directed bench for the half-bridge gate driver.
// Inputs change 1ns after a rising edge; outputs checked there too.
module tb_nmos_halfbridge_driver;

   localparam int CH = 4;
   localparam int DW = 8;

   logic clk;
   logic rst_n;
   int   vectors;
   int   errs;

   nmos_halfbridge_driver_if #(.CHANNELS(CH), .DEAD_W(DW)) bus ();

   nmos_halfbridge_driver #(.CHANNELS(CH), .DEAD_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [CH-1:0] got,
                      input logic [CH-1:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input logic [CH-1:0] hi,
                       input logic [CH-1:0] lo, input logic [CH-1:0] bsy);
      chk({tag, ".hi"}, bus.gate_hi, hi);
      chk({tag, ".lo"}, bus.gate_lo, lo);
      chk({tag, ".busy"}, bus.busy, bsy);
   endtask

   // Gates of a pair must never be on together
   always @(negedge clk) chk("inv_excl", bus.gate_hi & bus.gate_lo, 4'h0);

   initial begin
      vectors = 0;
      errs = 0;
      rst_n = 1'b0;
      bus.enable = 1'b1;
      bus.cmd = 4'b1010;
      bus.fault = 1'b0;
      bus.dead_time = 8'd3;
      step();
      step();
      outs("rst", 4'h0, 4'h0, 4'h0);
      chk("rst.fl", CH'(bus.fault_latched), 4'h0);

      bus.enable = 1'b0;
      bus.cmd = 4'b0000;
      rst_n = 1'b1;
      step();
      step();
      outs("idle", 4'h0, 4'h0, 4'h0);
      chk("idle.fl", CH'(bus.fault_latched), 4'h0);

      // Startup into low side with dead time 3
      bus.enable = 1'b1;
      step();
      outs("start1", 4'h0, 4'h0, 4'hF);
      step();
      outs("start2", 4'h0, 4'h0, 4'hF);
      step();
      outs("start3", 4'h0, 4'h0, 4'hF);
      step();
      outs("start4", 4'h0, 4'hF, 4'h0);

      // Commutate channel 0 low -> high
      bus.cmd = 4'b0001;
      step();
      outs("com1", 4'h0, 4'b1110, 4'b0001);
      step();
      outs("com2", 4'h0, 4'b1110, 4'b0001);
      step();
      outs("com3", 4'h0, 4'b1110, 4'b0001);
      step();
      outs("com4", 4'b0001, 4'b1110, 4'h0);

      // Zero dead time behaves as one cycle
      bus.dead_time = 8'd0;
      bus.cmd = 4'b0000;
      step();
      outs("dt0a", 4'h0, 4'b1110, 4'b0001);
      step();
      outs("dt0b", 4'h0, 4'hF, 4'h0);

      // Mid-dead changes of cmd and dead_time
      bus.dead_time = 8'd3;
      bus.cmd = 4'b0001;
      step();
      outs("mid1", 4'h0, 4'b1110, 4'b0001);
      bus.cmd = 4'b0000;
      bus.dead_time = 8'd10;
      step();
      outs("mid2", 4'h0, 4'b1110, 4'b0001);
      bus.cmd = 4'b0001;
      step();
      outs("mid3", 4'h0, 4'b1110, 4'b0001);
      step();
      outs("mid4", 4'b0001, 4'b1110, 4'h0);

      // Fault pulse while channel 0 is high
      bus.fault = 1'b1;
      step();
      outs("flt1", 4'h0, 4'h0, 4'h0);
      chk("flt1.fl", CH'(bus.fault_latched), 4'h1);
      bus.fault = 1'b0;
      step();
      step();
      outs("flt2", 4'h0, 4'h0, 4'h0);
      chk("flt2.fl", CH'(bus.fault_latched), 4'h1);
      bus.enable = 1'b0;
      step();
      outs("flt3", 4'h0, 4'h0, 4'h0);
      chk("flt3.fl", CH'(bus.fault_latched), 4'h0);

      // Fault and enable rise together: fault wins
      bus.fault = 1'b1;
      bus.enable = 1'b1;
      step();
      outs("fen", 4'h0, 4'h0, 4'h0);
      chk("fen.fl", CH'(bus.fault_latched), 4'h1);
      bus.fault = 1'b0;
      bus.enable = 1'b0;
      step();
      chk("fclr.fl", CH'(bus.fault_latched), 4'h0);

      // Re-enable passes through dead interval first
      bus.dead_time = 8'd2;
      bus.enable = 1'b1;
      step();
      outs("ren1", 4'h0, 4'h0, 4'hF);
      step();
      outs("ren2", 4'h0, 4'h0, 4'hF);
      step();
      outs("ren3", 4'b0001, 4'b1110, 4'h0);

      // Asynchronous reset in the middle of a dead interval
      bus.cmd = 4'b0000;
      step();
      outs("pre_ar", 4'h0, 4'b1110, 4'b0001);
      #2;
      rst_n = 1'b0;
      #1;
      outs("arst", 4'h0, 4'h0, 4'h0);
      chk("arst.fl", CH'(bus.fault_latched), 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
